// File: rtl/div_share_if.sv
// Requester/divider bus for div_share_arbiter: packed request operands, one-hot
// response, and the start/ready handshake to the shared divider.
interface div_share_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_dividend;
  logic [N_REQ*WIDTH-1:0] req_divisor;
  logic [N_REQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]       rsp_quotient;
  logic [WIDTH-1:0]       rsp_remainder;
  logic                   rsp_err;
  logic                   div_start;
  logic [WIDTH-1:0]       div_dividend;
  logic [WIDTH-1:0]       div_divisor;
  logic                   div_ready;
  logic [WIDTH-1:0]       div_quotient;
  logic [WIDTH-1:0]       div_remainder;

  modport slave (
    input  req_valid, req_dividend, req_divisor, div_ready, div_quotient, div_remainder,
    output rsp_valid, rsp_quotient, rsp_remainder, rsp_err, div_start, div_dividend, div_divisor
  );

  modport master (
    output req_valid, req_dividend, req_divisor, div_ready, div_quotient, div_remainder,
    input  rsp_valid, rsp_quotient, rsp_remainder, rsp_err, div_start, div_dividend, div_divisor
  );
endinterface

// File: rtl/div_share_arbiter.sv
// Round-robin sharing of one divider among N_REQ requesters; zero divisors are answered locally.
// Optional watchdog on the divider handshake: define DIV_ARB_TIMEOUT_EN.
module div_share_arbiter #(
  parameter int N_REQ       = 4,
  parameter int WIDTH       = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  div_share_if.slave               bus,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] grant_id
);
  localparam int IW = $clog2(N_REQ);

  // Elaboration-time parameter range guard; intentionally empty.
  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_params
  end

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_ACK, WAIT_DONE, RESP} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    rr_q, rr_d, grant_q, grant_d, sel, grant_nxt;
  logic             found;
  int               idx;
  logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d, dvs_q, dvs_d, sel_dvd, sel_dvs;
  logic             err_q, err_d, start_q, start_d, busy_q, busy_d;
`ifdef DIV_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0]    cnt_q, cnt_d;
`endif

  function automatic logic [N_REQ-1:0] onehot(input logic [IW-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  // First pending request at or above the rr pointer, wrapping.
  always_comb begin
    found = 1'b0;
    sel   = rr_q;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        sel   = IW'(idx);
      end
    end
    sel_dvd   = bus.req_dividend[int'(sel)*WIDTH +: WIDTH];
    sel_dvs   = bus.req_divisor[int'(sel)*WIDTH +: WIDTH];
    grant_nxt = (grant_q == IW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    grant_d     = grant_q;
    rsp_valid_d = '0;
    quot_d      = quot_q;
    rem_d       = rem_q;
    err_d       = err_q;
    start_d     = 1'b0;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
`ifdef DIV_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.div_ready && found) begin
          grant_d = sel;
          dvd_d   = sel_dvd;
          dvs_d   = sel_dvs;
          if (sel_dvs == '0) begin
            state_d     = RESP;
            rsp_valid_d = onehot(sel);
            err_d       = 1'b1;
            quot_d      = '1;
            rem_d       = sel_dvd;
          end else begin
            state_d = LAUNCH;
            start_d = 1'b1;
          end
        end
      end
      LAUNCH: begin
        state_d = WAIT_ACK;
`ifdef DIV_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT_ACK: begin
        if (!bus.div_ready) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (bus.div_ready) begin
          state_d     = RESP;
          rsp_valid_d = onehot(grant_q);
          quot_d      = bus.div_quotient;
          rem_d       = bus.div_remainder;
          err_d       = 1'b0;
        end
      end
      RESP: begin
        rr_d    = grant_nxt;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef DIV_ARB_TIMEOUT_EN
    // A completion on the expiry cycle still wins over the watchdog.
    if ((state_q == WAIT_ACK || state_q == WAIT_DONE) && state_d != RESP) begin
      if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
        state_d     = RESP;
        rsp_valid_d = onehot(grant_q);
        quot_d      = '0;
        rem_d       = '0;
        err_d       = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
`endif
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      grant_q     <= '0;
      rsp_valid_q <= '0;
      quot_q      <= '0;
      rem_q       <= '0;
      err_q       <= 1'b0;
      start_q     <= 1'b0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      busy_q      <= 1'b0;
`ifdef DIV_ARB_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      grant_q     <= grant_d;
      rsp_valid_q <= rsp_valid_d;
      quot_q      <= quot_d;
      rem_q       <= rem_d;
      err_q       <= err_d;
      start_q     <= start_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      busy_q      <= busy_d;
`ifdef DIV_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_quotient  = quot_q;
  assign bus.rsp_remainder = rem_q;
  assign bus.rsp_err       = err_q;
  assign bus.div_start     = start_q;
  assign bus.div_dividend  = dvd_q;
  assign bus.div_divisor   = dvs_q;
  assign busy              = busy_q;
  assign grant_id          = grant_q;
endmodule

// File: tb/tb_div_share_arbiter.sv
// Directed bench for div_share_arbiter with a behavioural divider that drops
// ready after start and returns results after dm_lat cycles.
module tb_div_share_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         busy;
  logic [1:0]   grant_id;
  int           n_chk = 0;
  int           n_fail = 0;
  int           n_start = 0;

  logic         dm_ready = 1'b1;
  logic         dm_hang = 1'b0;
  logic         hold_low = 1'b0;
  int           dm_lat = 3;
  int           dm_cnt = 0;
  logic [W-1:0] dm_a = '0, dm_b = '0, dm_q = '0, dm_r = '0;

  div_share_if #(.N_REQ(N), .WIDTH(W)) bus ();

  div_share_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  assign bus.div_ready     = dm_ready & ~hold_low;
  assign bus.div_quotient  = dm_q;
  assign bus.div_remainder = dm_r;

  always @(negedge clk) begin
    if (bus.div_start) n_start++;
    if (dm_cnt > 0) begin
      if (!dm_hang) begin
        dm_cnt = dm_cnt - 1;
        if (dm_cnt == 0) begin
          dm_q     = dm_a / dm_b;
          dm_r     = dm_a % dm_b;
          dm_ready = 1'b1;
        end
      end
    end else if (dm_ready && bus.div_start) begin
      dm_a     = bus.div_dividend;
      dm_b     = bus.div_divisor;
      dm_ready = 1'b0;
      dm_cnt   = dm_lat;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.req_dividend[i*W +: W] = a;
    bus.req_divisor[i*W +: W]  = b;
    bus.req_valid[i]           = 1'b1;
  endtask

  // Returns cycles until a response pulse, or -1 if the budget runs out.
  task automatic wait_rsp(input int budget, output int cyc);
    cyc = -1;
    for (int c = 1; c <= budget; c++) begin
      tick();
      if (bus.rsp_valid != '0) begin
        cyc = c;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    n_chk++; if (bus.rsp_valid !== 4'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0000", bus.rsp_valid); end
    n_chk++; if (bus.rsp_quotient !== 8'd0 || bus.rsp_remainder !== 8'd0 || bus.rsp_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_rsp_data got q=%0d r=%0d e=%b want 0 0 0", bus.rsp_quotient, bus.rsp_remainder, bus.rsp_err); end
    n_chk++; if (busy !== 1'b0 || grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_busy_grant got %b %0d want 0 0", busy, grant_id); end
    n_chk++; if (bus.div_start !== 1'b0 || bus.div_dividend !== 8'd0 || bus.div_divisor !== 8'd0) begin
      n_fail++; $display("FAIL reset_div_out got s=%b a=%0d b=%0d want 0 0 0", bus.div_start, bus.div_dividend, bus.div_divisor); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int cyc;
    n_start = 0;
    set_req(0, 8'd100, 8'd7);
    wait_rsp(40, cyc);
    n_chk++; if (cyc !== 5) begin n_fail++; $display("FAIL single_latency got %0d want 5", cyc); end
    n_chk++; if (bus.rsp_valid !== 4'b0001) begin n_fail++; $display("FAIL single_rsp_valid got %b want 0001", bus.rsp_valid); end
    n_chk++; if (bus.rsp_quotient !== 8'd14 || bus.rsp_remainder !== 8'd2 || bus.rsp_err !== 1'b0) begin
      n_fail++; $display("FAIL single_result got q=%0d r=%0d e=%b want 14 2 0", bus.rsp_quotient, bus.rsp_remainder, bus.rsp_err); end
    n_chk++; if (n_start !== 1) begin n_fail++; $display("FAIL single_start_pulses got %0d want 1", n_start); end
    bus.req_valid = '0;
    tick();
    n_chk++; if (bus.rsp_valid !== 4'b0 || bus.rsp_quotient !== 8'd14) begin
      n_fail++; $display("FAIL single_pulse_hold got v=%b q=%0d want 0000 14", bus.rsp_valid, bus.rsp_quotient); end
    tick();
  endtask

  task automatic test_zero_div();
    int cyc;
    n_start = 0;
    set_req(2, 8'd55, 8'd0);
    wait_rsp(10, cyc);
    n_chk++; if (cyc !== 1) begin n_fail++; $display("FAIL zero_latency got %0d want 1", cyc); end
    n_chk++; if (bus.rsp_valid !== 4'b0100) begin n_fail++; $display("FAIL zero_rsp_valid got %b want 0100", bus.rsp_valid); end
    n_chk++; if (bus.rsp_quotient !== 8'd255 || bus.rsp_remainder !== 8'd55 || bus.rsp_err !== 1'b1) begin
      n_fail++; $display("FAIL zero_result got q=%0d r=%0d e=%b want 255 55 1", bus.rsp_quotient, bus.rsp_remainder, bus.rsp_err); end
    bus.req_valid = '0;
    tick(); tick();
    n_chk++; if (n_start !== 0 || busy !== 1'b0) begin n_fail++; $display("FAIL zero_no_start got starts=%0d busy=%b want 0 0", n_start, busy); end
  endtask

  task automatic test_round_robin();
    int cyc;
    int       ord[6] = '{0, 1, 2, 3, 0, 2};
    logic [7:0] eq[6] = '{8'd22, 8'd15, 8'd15, 8'd0, 8'd9, 8'd8};
    logic [7:0] er[6] = '{8'd2, 8'd2, 8'd15, 8'd13, 8'd9, 8'd0};
    logic [3:0] oh;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    set_req(0, 8'd200, 8'd9);
    set_req(1, 8'd77, 8'd5);
    set_req(2, 8'd255, 8'd16);
    set_req(3, 8'd13, 8'd20);
    for (int k = 0; k < 6; k++) begin
      wait_rsp(40, cyc);
      oh = 4'b0001 << ord[k];
      n_chk++; if (cyc < 0 || bus.rsp_valid !== oh || grant_id !== 2'(ord[k])) begin
        n_fail++; $display("FAIL rr_grant_%0d got v=%b g=%0d want %b %0d", k, bus.rsp_valid, grant_id, oh, ord[k]); end
      n_chk++; if (bus.rsp_quotient !== eq[k] || bus.rsp_remainder !== er[k] || bus.rsp_err !== 1'b0) begin
        n_fail++; $display("FAIL rr_result_%0d got q=%0d r=%0d e=%b want %0d %0d 0", k, bus.rsp_quotient, bus.rsp_remainder, bus.rsp_err, eq[k], er[k]); end
      bus.req_valid = bus.req_valid & ~bus.rsp_valid;
      if (k == 3) begin
        set_req(2, 8'd64, 8'd8);
        set_req(0, 8'd99, 8'd10);
      end
    end
    tick();
  endtask

  task automatic test_not_ready();
    int cyc;
    hold_low = 1'b1;
    set_req(1, 8'd50, 8'd6);
    for (int c = 0; c < 4; c++) begin
      tick();
      n_chk++; if (busy !== 1'b0 || bus.div_start !== 1'b0) begin
        n_fail++; $display("FAIL notready_idle_%0d got busy=%b start=%b want 0 0", c, busy, bus.div_start); end
    end
    hold_low = 1'b0;
    tick();
    n_chk++; if (bus.div_start !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL notready_launch got start=%b busy=%b want 1 1", bus.div_start, busy); end
    wait_rsp(40, cyc);
    n_chk++; if (cyc < 0 || bus.rsp_valid !== 4'b0010 || bus.rsp_quotient !== 8'd8 || bus.rsp_remainder !== 8'd2) begin
      n_fail++; $display("FAIL notready_result got v=%b q=%0d r=%0d want 0010 8 2", bus.rsp_valid, bus.rsp_quotient, bus.rsp_remainder); end
    bus.req_valid = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    int cyc;
    logic relaunched = 1'b0;
    dm_lat = 8;
    set_req(3, 8'd120, 8'd11);
    tick();
    n_chk++; if (bus.div_start !== 1'b1) begin n_fail++; $display("FAIL mid_launch got %b want 1", bus.div_start); end
    tick(); tick();
    rst_n = 1'b0;
    dm_lat = 3;
    tick();
    rst_n = 1'b1;
    n_chk++; if (busy !== 1'b0 || bus.rsp_valid !== 4'b0 || bus.div_start !== 1'b0 || grant_id !== 2'd0 ||
                 bus.div_dividend !== 8'd0 || bus.div_divisor !== 8'd0 || bus.rsp_quotient !== 8'd0) begin
      n_fail++; $display("FAIL mid_reset_vals got busy=%b v=%b s=%b g=%0d a=%0d b=%0d q=%0d want all 0",
                         busy, bus.rsp_valid, bus.div_start, grant_id, bus.div_dividend, bus.div_divisor, bus.rsp_quotient); end
    for (int c = 0; c < 20 && !relaunched; c++) begin
      tick();
      if (bus.div_ready) begin
        relaunched = 1'b1;
        n_chk++; if (bus.div_start !== 1'b1) begin n_fail++; $display("FAIL mid_relaunch got start=%b want 1", bus.div_start); end
      end else begin
        n_chk++; if (busy !== 1'b0 || bus.div_start !== 1'b0 || bus.rsp_valid !== 4'b0) begin
          n_fail++; $display("FAIL mid_hold_%0d got busy=%b s=%b v=%b want 0 0 0000", c, busy, bus.div_start, bus.rsp_valid); end
      end
    end
    n_chk++; if (!relaunched) begin n_fail++; $display("FAIL mid_ready_timeout got none want relaunch"); end
    wait_rsp(40, cyc);
    n_chk++; if (cyc < 0 || bus.rsp_valid !== 4'b1000 || bus.rsp_quotient !== 8'd10 || bus.rsp_remainder !== 8'd10) begin
      n_fail++; $display("FAIL mid_result got v=%b q=%0d r=%0d want 1000 10 10", bus.rsp_valid, bus.rsp_quotient, bus.rsp_remainder); end
    bus.req_valid = '0;
    tick();
  endtask

`ifdef DIV_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int cyc;
    dm_hang = 1'b1;
    set_req(0, 8'd10, 8'd3);
    tick();
    n_chk++; if (bus.div_start !== 1'b1) begin n_fail++; $display("FAIL to_launch got %b want 1", bus.div_start); end
    tick();
    wait_rsp(40, cyc);
    n_chk++; if (cyc !== 16) begin n_fail++; $display("FAIL to_latency got %0d want 16", cyc); end
    n_chk++; if (bus.rsp_valid !== 4'b0001 || bus.rsp_err !== 1'b1 || bus.rsp_quotient !== 8'd0 || bus.rsp_remainder !== 8'd0) begin
      n_fail++; $display("FAIL to_result got v=%b e=%b q=%0d r=%0d want 0001 1 0 0", bus.rsp_valid, bus.rsp_err, bus.rsp_quotient, bus.rsp_remainder); end
    bus.req_valid = '0;
    tick(); tick();
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL to_no_regrant got busy=%b want 0", busy); end
  endtask
`endif

  initial begin
    bus.req_valid    = '0;
    bus.req_dividend = '0;
    bus.req_divisor  = '0;
    test_reset();
    test_single();
    test_zero_div();
    test_round_robin();
    test_not_ready();
    test_reset_mid();
`ifdef DIV_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
